// File: rtl/uno_pkg.sv
// Shared types and constants for the UNO card datapath.
package uno_pkg;

  typedef struct packed {
    logic [1:0] colour;
    logic [3:0] value;
  } card_t;

  localparam card_t      CARD_EMPTY  = '{colour: 2'b11, value: 4'hF};
  localparam logic [3:0] VAL_WILD    = 4'd13;
  localparam logic [3:0] VAL_WILD4   = 4'd14;
  localparam int         DECK_SIZE   = 108;
  localparam int         HAND_INIT   = 7;
  localparam int         NUM_PLAYERS = 4;
  localparam int         DEAL_CARDS  = HAND_INIT * NUM_PLAYERS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHUFFLE,
    ST_DEAL,
    ST_FIRST,
    ST_READY
  } state_e;

  // Smallest 2^k-1 covering i, so rejection sampling stays below 50% misses.
  function automatic logic [6:0] shuffle_mask(input logic [6:0] i);
    if (i >= 7'd64)      return 7'd127;
    else if (i >= 7'd32) return 7'd63;
    else if (i >= 7'd16) return 7'd31;
    else if (i >= 7'd8)  return 7'd15;
    else if (i >= 7'd4)  return 7'd7;
    else if (i >= 7'd2)  return 7'd3;
    else                 return 7'd1;
  endfunction

endpackage

// File: rtl/uno_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); exposes the low bits.
module uno_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       i_clk_1M,
  input  logic       i_rst_n,
  output logic [6:0] o_rand
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign o_rand = lfsr_q[6:0];

  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) lfsr_q <= SEED;
    else          lfsr_q <= {lfsr_q[14:0], fb};
  end

endmodule

// File: rtl/uno_deck_dealer.sv
// Builds, shuffles and deals the 108-card UNO deck, then serves single-card draws.
module uno_deck_dealer
  import uno_pkg::*;
#(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter bit          SHUFFLE_EN = 1'b1
) (
  input  logic       i_clk_1M,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_draw,
  input  logic [1:0] i_draw_player,
  output logic [5:0] o_card,
  output logic       o_card_valid,
  output logic [1:0] o_card_player,
  output logic       o_first,
  output logic       o_busy,
  output logic       o_ready,
  output logic [6:0] o_remaining,
  output logic       o_empty
);

  localparam logic [6:0] LAST_IDX = 7'(DECK_SIZE - 1);
  localparam logic [6:0] DEAL_LAST = 7'(DEAL_CARDS - 1);

  function automatic card_t canon(input logic [6:0] n);
    card_t      c;
    logic [6:0] r;
    c = CARD_EMPTY;
    r = n;
    if (n < 7'd100) begin
      if (n >= 7'd75)      begin c.colour = 2'd3; r = n - 7'd75; end
      else if (n >= 7'd50) begin c.colour = 2'd2; r = n - 7'd50; end
      else if (n >= 7'd25) begin c.colour = 2'd1; r = n - 7'd25; end
      else                 begin c.colour = 2'd0; r = n;         end
      c.value = (r == 7'd0) ? 4'd0 : 4'(((r - 7'd1) >> 1) + 7'd1);
    end else begin
      c.colour = n[1:0];
      c.value  = (n < 7'd104) ? VAL_WILD : VAL_WILD4;
    end
    return c;
  endfunction

  card_t      deck_q [0:DECK_SIZE-1];
  state_e     state_q;
  card_t      card_q;
  logic       valid_q, first_q, busy_q, ready_q, empty_q;
  logic [1:0] player_q;
  logic [6:0] remaining_q;
  logic [6:0] idx_q;   // shuffle i, deal count, or wild-swap pointer p

  logic [6:0] rnd;
  logic [6:0] rnd_j;
  logic [6:0] top_idx;
  card_t      top_card;
  logic       swap_ok;
  logic       top_wild;

  uno_lfsr16 #(.SEED(SEED)) u_lfsr (
    .i_clk_1M (i_clk_1M),
    .i_rst_n  (i_rst_n),
    .o_rand   (rnd)
  );

  assign rnd_j    = rnd & shuffle_mask(idx_q);
  assign swap_ok  = (rnd_j <= idx_q);
  assign top_idx  = remaining_q - 7'd1;
  assign top_card = deck_q[top_idx];
  assign top_wild = (top_card.value >= VAL_WILD);

  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      card_q      <= CARD_EMPTY;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      player_q    <= 2'd0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      remaining_q <= 7'd0;
      empty_q     <= 1'b1;
      idx_q       <= 7'd0;
    end else begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      if (i_start) begin
        state_q     <= ST_INIT;
        busy_q      <= 1'b1;
        ready_q     <= 1'b0;
        remaining_q <= 7'd0;
        empty_q     <= 1'b1;
        idx_q       <= 7'd0;
      end else begin
        case (state_q)
          // remaining_q doubles as the write index n while building
          ST_INIT: begin
            remaining_q <= remaining_q + 7'd1;
            empty_q     <= 1'b0;
            if (remaining_q == LAST_IDX) begin
              state_q <= SHUFFLE_EN ? ST_SHUFFLE : ST_DEAL;
              idx_q   <= SHUFFLE_EN ? LAST_IDX : 7'd0;
            end
          end
          ST_SHUFFLE: begin
            if (swap_ok) begin
              idx_q <= idx_q - 7'd1;
              if (idx_q == 7'd1) begin
                state_q <= ST_DEAL;
                idx_q   <= 7'd0;
              end
            end
          end
          ST_DEAL: begin
            card_q      <= top_card;
            valid_q     <= 1'b1;
            player_q    <= idx_q[1:0];
            remaining_q <= remaining_q - 7'd1;
            empty_q     <= (remaining_q == 7'd1);
            idx_q       <= idx_q + 7'd1;
            if (idx_q == DEAL_LAST) begin
              state_q <= ST_FIRST;
              idx_q   <= 7'd0;
            end
          end
          ST_FIRST: begin
            if (top_wild) begin
              idx_q <= idx_q + 7'd1;
            end else begin
              card_q      <= top_card;
              valid_q     <= 1'b1;
              first_q     <= 1'b1;
              player_q    <= 2'd0;
              remaining_q <= remaining_q - 7'd1;
              empty_q     <= (remaining_q == 7'd1);
              state_q     <= ST_READY;
              busy_q      <= 1'b0;
              ready_q     <= 1'b1;
            end
          end
          ST_READY: begin
            if (i_draw && !empty_q) begin
              card_q      <= top_card;
              valid_q     <= 1'b1;
              player_q    <= i_draw_player;
              remaining_q <= remaining_q - 7'd1;
              empty_q     <= (remaining_q == 7'd1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Deck storage carries no reset; INIT rewrites every entry before use.
  always_ff @(posedge i_clk_1M) begin
    case (state_q)
      ST_INIT: deck_q[remaining_q] <= canon(remaining_q);
      ST_SHUFFLE: begin
        if (swap_ok) begin
          deck_q[idx_q] <= deck_q[rnd_j];
          deck_q[rnd_j] <= deck_q[idx_q];
        end
      end
      ST_FIRST: begin
        if (top_wild) begin
          deck_q[top_idx] <= deck_q[idx_q];
          deck_q[idx_q]   <= top_card;
        end
      end
      default: ;
    endcase
  end

  assign o_card        = card_q;
  assign o_card_valid  = valid_q;
  assign o_card_player = player_q;
  assign o_first       = first_q;
  assign o_busy        = busy_q;
  assign o_ready       = ready_q;
  assign o_remaining   = remaining_q;
  assign o_empty       = empty_q;

endmodule

// File: tb/tb_uno_deck_dealer.sv
// Directed bench: deterministic deck (dut0) plus two shuffled decks with different seeds.
module tb_uno_deck_dealer;

  typedef struct {
    logic [5:0] card;
    logic [1:0] pl;
    logic       first;
    logic [6:0] rem;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       draw = 1'b0;
  logic [1:0] dpl = 2'd0;

  logic [5:0] card  [3];
  logic       valid [3];
  logic [1:0] pl    [3];
  logic       first [3];
  logic       busy  [3];
  logic       ready [3];
  logic [6:0] rem   [3];
  logic       empty [3];

  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uno_deck_dealer #(.SEED(16'hACE1), .SHUFFLE_EN(1'b0)) u_dut0 (
    .i_clk_1M(clk), .i_rst_n(rst_n), .i_start(start), .i_draw(draw), .i_draw_player(dpl),
    .o_card(card[0]), .o_card_valid(valid[0]), .o_card_player(pl[0]), .o_first(first[0]),
    .o_busy(busy[0]), .o_ready(ready[0]), .o_remaining(rem[0]), .o_empty(empty[0]));

  uno_deck_dealer #(.SEED(16'hACE1), .SHUFFLE_EN(1'b1)) u_dut1 (
    .i_clk_1M(clk), .i_rst_n(rst_n), .i_start(start), .i_draw(draw), .i_draw_player(dpl),
    .o_card(card[1]), .o_card_valid(valid[1]), .o_card_player(pl[1]), .o_first(first[1]),
    .o_busy(busy[1]), .o_ready(ready[1]), .o_remaining(rem[1]), .o_empty(empty[1]));

  uno_deck_dealer #(.SEED(16'h1D35), .SHUFFLE_EN(1'b1)) u_dut2 (
    .i_clk_1M(clk), .i_rst_n(rst_n), .i_start(start), .i_draw(draw), .i_draw_player(dpl),
    .o_card(card[2]), .o_card_valid(valid[2]), .o_card_player(pl[2]), .o_first(first[2]),
    .o_busy(busy[2]), .o_ready(ready[2]), .o_remaining(rem[2]), .o_empty(empty[2]));

  function automatic ev_t mk(input int d);
    ev_t e;
    e.card  = card[d];
    e.pl    = pl[d];
    e.first = first[d];
    e.rem   = rem[d];
    e.cyc   = cyc;
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst_n && valid[0]) q0.push_back(mk(0));
    if (rst_n && valid[1]) q1.push_back(mk(1));
    if (rst_n && valid[2]) q2.push_back(mk(2));
  end

  // Reference card for build position n.
  function automatic logic [5:0] canon(input int n);
    int         c, r, v;
    logic [1:0] col;
    logic [3:0] val;
    if (n < 100) begin
      c = n / 25;
      r = n % 25;
      v = (r == 0) ? 0 : 1 + (r - 1) / 2;
      col = 2'(c);
      val = 4'(v);
    end else begin
      col = 2'(n % 4);
      val = (n < 104) ? 4'd13 : 4'd14;
    end
    return {col, val};
  endfunction

  function automatic int hist_mismatch(input int d);
    int h[64];
    int sz, bad;
    for (int i = 0; i < 64; i++) h[i] = 0;
    for (int n = 0; n < 108; n++) h[int'(canon(n))]++;
    sz = (d == 1) ? q1.size() : q2.size();
    for (int i = 0; i < sz; i++) h[int'((d == 1) ? q1[i].card : q2[i].card)]--;
    bad = 0;
    for (int i = 0; i < 64; i++) if (h[i] != 0) bad++;
    return bad;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input int d, input int budget);
    int n;
    n = 0;
    while (ready[d] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_dut%0d", d), 32'(ready[d]), 1);
  endtask

  task automatic check_reset(input int d, input string tag);
    check({tag, "_card"},  32'(card[d]),  32'h3F);
    check({tag, "_valid"}, 32'(valid[d]), 0);
    check({tag, "_first"}, 32'(first[d]), 0);
    check({tag, "_pl"},    32'(pl[d]),    0);
    check({tag, "_busy"},  32'(busy[d]),  0);
    check({tag, "_ready"}, 32'(ready[d]), 0);
    check({tag, "_rem"},   32'(rem[d]),   0);
    check({tag, "_empty"}, 32'(empty[d]), 1);
  endtask

  initial begin
    int         t_start, diff, base0, base1, n, drops, sz0, sz1;
    logic [5:0] seq1 [29];
    logic [1:0] exp_pl [79];

    // Reset values, then start all three decks together.
    repeat (3) @(negedge clk);
    check_reset(0, "rst0");
    check_reset(1, "rst1");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    t_start = cyc;
    pulse_start();
    check("busy_t1", 32'(busy[0]), 1);
    check("ready_t1", 32'(ready[0]), 0);
    check("valid_t1", 32'(valid[0]), 0);
    wait_ready(0, 4000);
    wait_ready(1, 4000);
    wait_ready(2, 4000);

    // Deterministic deal: pops from index 107 downward.
    check("deal_count0", q0.size(), 29);
    if (q0.size() >= 29) begin
      check("deal_latency", q0[0].cyc - t_start, 110);
      check("deal_first_card", 32'(q0[0].card), 32'h3E);
      check("deal_last_card", 32'(q0[27].card), 32'h33);
      for (int k = 0; k < 28; k++) begin
        check($sformatf("deal_card%0d", k), 32'(q0[k].card), 32'(canon(107 - k)));
        check($sformatf("deal_pl%0d", k), 32'(q0[k].pl), k % 4);
        check($sformatf("deal_first%0d", k), 32'(q0[k].first), 0);
        check($sformatf("deal_rem%0d", k), 32'(q0[k].rem), 107 - k);
      end
      check("disc_card", 32'(q0[28].card), 32'h32);
      check("disc_first", 32'(q0[28].first), 1);
      check("disc_pl", 32'(q0[28].pl), 0);
      check("disc_rem", 32'(q0[28].rem), 79);
    end
    check("ready0_busy", 32'(busy[0]), 0);
    check("ready0_rem", 32'(rem[0]), 79);
    check("ready0_empty", 32'(empty[0]), 0);

    // Shuffled decks: legal first discard, seeds diverge.
    check("deal_count1", q1.size(), 29);
    check("deal_count2", q2.size(), 29);
    if (q1.size() >= 29 && q2.size() >= 29) begin
      check("disc1_first", 32'(q1[28].first), 1);
      check("disc1_notwild", 32'(q1[28].card[3:0] < 4'd13), 1);
      check("disc2_notwild", 32'(q2[28].card[3:0] < 4'd13), 1);
      diff = 0;
      for (int k = 0; k < 28; k++) begin
        check($sformatf("deal1_pl%0d", k), 32'(q1[k].pl), k % 4);
        if (q1[k].card != q2[k].card) diff++;
      end
      check("seeds_differ", 32'(diff != 0), 1);
      for (int k = 0; k < 29; k++) seq1[k] = q1[k].card;
    end else begin
      for (int k = 0; k < 29; k++) seq1[k] = 6'h3F;
    end

    // Back-to-back draws until every deck is empty.
    for (int i = 0; i < 79; i++) begin
      draw = 1'b1;
      dpl = (i == 0) ? 2'd2 : 2'(i % 4);
      exp_pl[i] = dpl;
      @(negedge clk);
      if (i == 0) begin
        check("draw1_valid", 32'(valid[0]), 1);
        check("draw1_card", 32'(card[0]), 32'h32);
        check("draw1_pl", 32'(pl[0]), 2);
        check("draw1_rem", 32'(rem[0]), 78);
      end
    end
    draw = 1'b0;
    check("drain_count0", q0.size(), 108);
    if (q0.size() >= 108) begin
      for (int i = 0; i < 79; i++) begin
        check($sformatf("draw_card%0d", i), 32'(q0[29 + i].card), 32'(canon(78 - i)));
        check($sformatf("draw_pl%0d", i), 32'(q0[29 + i].pl), 32'(exp_pl[i]));
        check($sformatf("draw_rem%0d", i), 32'(q0[29 + i].rem), 78 - i);
      end
    end
    check("empty0", 32'(empty[0]), 1);
    check("rem0_zero", 32'(rem[0]), 0);
    check("empty1", 32'(empty[1]), 1);
    check("drain_count1", q1.size(), 108);
    check("multiset1", hist_mismatch(1), 0);
    check("multiset2", hist_mismatch(2), 0);

    // Draw on an empty deck is ignored.
    draw = 1'b1;
    dpl = 2'd1;
    @(negedge clk);
    draw = 1'b0;
    repeat (2) @(negedge clk);
    check("empty_draw0", q0.size(), 108);
    check("empty_draw1", q1.size(), 108);
    check("empty_valid", 32'(valid[0]), 0);

    // Same seed, same start cycle after reset: identical deal.
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    pulse_start();
    wait_ready(1, 4000);
    check("replay_count", q1.size(), 29);
    diff = 0;
    for (int k = 0; k < 29; k++) if (k >= q1.size() || q1[k].card != seq1[k]) diff++;
    check("replay_same", diff, 0);
    wait_ready(0, 4000);
    wait_ready(2, 4000);

    // Restart in the middle of DEAL.
    pulse_start();
    base0 = q0.size();
    n = 0;
    while (q0.size() - base0 < 10 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("pre_restart_count", q0.size() - base0, 10);
    pulse_start();
    check("restart_suppress", q0.size() - base0, 10);
    check("restart_valid", 32'(valid[0]), 0);
    check("restart_busy", 32'(busy[0]), 1);
    base1 = q0.size();
    drops = 0;
    n = 0;
    while (ready[0] !== 1'b1 && n < 400) begin
      if (busy[0] !== 1'b1) drops++;
      @(negedge clk);
      n++;
    end
    check("restart_ready", 32'(ready[0]), 1);
    check("restart_busy_held", drops, 0);
    check("restart_count", q0.size() - base1, 29);
    if (q0.size() - base1 >= 29) begin
      check("restart_card0", 32'(q0[base1].card), 32'h3E);
      check("restart_disc", 32'(q0[base1 + 28].card), 32'h32);
      check("restart_disc_first", 32'(q0[base1 + 28].first), 1);
    end

    // Reset while the shuffled deck is mid-SHUFFLE.
    pulse_start();
    repeat (149) @(negedge clk);
    check("mid_shuf_busy", 32'(busy[1]), 1);
    check("mid_shuf_rem", 32'(rem[1]), 108);
    check("mid_shuf_ready", 32'(ready[1]), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset(1, "rst_shuf");
    q1.delete();
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    sz1 = q1.size();
    sz0 = int'(busy[1]) + int'(ready[1]);
    check("post_rst_strobes", sz1, 0);
    check("post_rst_state", sz0, 0);
    check("post_rst_card", 32'(card[1]), 32'h3F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
